// File: rtl/obstacle_pkg.sv
// Shared types and helpers for the obstacle echo ranger.
package obstacle_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StReport,
        StHoldoff
    } ranger_state_t;

    // Channel index width, kept at least one bit so a single-channel build still has a port.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obstacle_hyst_filter.sv
// Debounced hysteresis for one channel's near flag: FILTER_N consecutive opposing hits toggle it.
module obstacle_hyst_filter #(
    parameter int unsigned FILTER_N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic update,
    input  logic near_hit,
    input  logic far_hit,
    output logic near
);

    logic [2:0] agree_q, agree_d;
    logic       near_q, near_d;
    logic       opposing;

    always_comb begin
        agree_d  = agree_q;
        near_d   = near_q;
        opposing = near_q ? far_hit : near_hit;
        if (update) begin
            // Agreeing and neutral results both break the streak.
            if (opposing) begin
                if (agree_q + 3'd1 >= 3'(FILTER_N)) begin
                    near_d  = ~near_q;
                    agree_d = '0;
                end else begin
                    agree_d = agree_q + 3'd1;
                end
            end else begin
                agree_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            agree_q <= '0;
            near_q  <= 1'b0;
        end else begin
            agree_q <= agree_d;
            near_q  <= near_d;
        end
    end

    assign near = near_q;

endmodule

// File: rtl/obstacle_echo_ranger.sv
// Round-robin ultrasonic ranger: fires each sensor in turn, times its echo and
// feeds the result into a per-channel near/far hysteresis filter.
module obstacle_echo_ranger
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TRIG_CYCLES    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 40000,
    parameter int unsigned HOLDOFF_CYCLES = 600,
    parameter int unsigned FILTER_N       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       echo,
    input  logic [CNT_W-1:0]        thr_near,
    input  logic [CNT_W-1:0]        thr_far,
    output logic [NUM_CH-1:0]       trig,
    output logic [NUM_CH-1:0]       near,
    output logic                    range_valid,
    output logic [ch_w(NUM_CH)-1:0] range_ch,
    output logic [CNT_W-1:0]        range_value,
    output logic                    range_timeout
);

    localparam int unsigned CH_W    = ch_w(NUM_CH);
    localparam int unsigned TMR_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES
                                                                     : HOLDOFF_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST    = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ranger_state_t     state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [NUM_CH-1:0] trig_q, trig_d;
    logic [NUM_CH-1:0] echo_meta_q, echo_s_q;

    logic              range_valid_q;
    logic [CH_W-1:0]   range_ch_q;
    logic [CNT_W-1:0]  range_value_q;
    logic              range_timeout_q;

    logic              echo_sel;
    logic              report_go;
    logic [CNT_W-1:0]  res_value;
    logic              res_timeout;
    logic              res_near_hit;
    logic              res_far_hit;

    assign echo_sel = echo_s_q[ch_q];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        report_go   = 1'b0;
        res_value   = cnt_q;
        res_timeout = 1'b0;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StTrig;
                    tmr_d   = '0;
                end
            end
            StTrig: begin
                if (tmr_q == TRIG_LAST) begin
                    state_d = StWaitRise;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            StWaitRise: begin
                if (echo_sel) begin
                    state_d = StMeasure;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TIMEOUT_LAST) begin
                    report_go   = 1'b1;
                    res_value   = TIMEOUT_VAL;
                    res_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StMeasure: begin
                if (!echo_sel) begin
                    report_go = 1'b1;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    // Echo would reach the limit this cycle: stop before the counter can wrap.
                    report_go   = 1'b1;
                    res_value   = TIMEOUT_VAL;
                    res_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StReport: begin
                state_d = StHoldoff;
                tmr_d   = '0;
            end
            StHoldoff: begin
                if (tmr_q == HOLD_LAST) begin
                    ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
                    state_d = en ? StTrig : StIdle;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (report_go) state_d = StReport;

        trig_d = '0;
        if (state_d == StTrig) trig_d[ch_d] = 1'b1;
    end

    // A timeout is always far, never near, whatever the thresholds are.
    assign res_near_hit = !res_timeout && (res_value < thr_near);
    assign res_far_hit  = res_timeout || (res_value >= thr_far);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            ch_q            <= '0;
            cnt_q           <= '0;
            tmr_q           <= '0;
            trig_q          <= '0;
            echo_meta_q     <= '0;
            echo_s_q        <= '0;
            range_valid_q   <= 1'b0;
            range_ch_q      <= '0;
            range_value_q   <= '0;
            range_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            trig_q        <= trig_d;
            echo_meta_q   <= echo;
            echo_s_q      <= echo_meta_q;
            range_valid_q <= report_go;
            if (report_go) begin
                range_ch_q      <= ch_q;
                range_value_q   <= res_value;
                range_timeout_q <= res_timeout;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_filter
        obstacle_hyst_filter #(
            .FILTER_N(FILTER_N)
        ) u_filter (
            .clk     (clk),
            .rst     (rst),
            .update  (report_go && (ch_q == CH_W'(i))),
            .near_hit(res_near_hit),
            .far_hit (res_far_hit),
            .near    (near[i])
        );
    end

    assign trig          = trig_q;
    assign range_valid   = range_valid_q;
    assign range_ch      = range_ch_q;
    assign range_value   = range_value_q;
    assign range_timeout = range_timeout_q;

endmodule
